// File: rtl/dcache_wb_axi_pkg.sv
// Shared encodings for the dcache write-back AXI master: request types, FSM states and
// AXI burst/size constants.
package dcache_wb_axi_pkg;

    localparam logic [2:0] WrByte = 3'b000;
    localparam logic [2:0] WrHalf = 3'b001;
    localparam logic [2:0] WrWord = 3'b010;
    localparam logic [2:0] WrLine = 3'b100;

    typedef enum logic [1:0] {
        StIdle,
        StAw,
        StW,
        StB
    } state_e;

    localparam logic [1:0] AxiBurstIncr = 2'b01;
    localparam logic [2:0] AxiSize1B    = 3'b000;
    localparam logic [2:0] AxiSize2B    = 3'b001;
    localparam logic [2:0] AxiSize4B    = 3'b010;
    localparam logic [7:0] AxiLenLine   = 8'd3;
    localparam logic [7:0] AxiLenSingle = 8'd0;

    function automatic logic [2:0] axi_size(input logic [2:0] wr_type);
        unique case (wr_type)
            WrByte:  return AxiSize1B;
            WrHalf:  return AxiSize2B;
            default: return AxiSize4B;
        endcase
    endfunction

endpackage

// File: rtl/dcache_wb_axi.sv
// Single-entry dcache write buffer: captures one byte/half/word/line write and issues it as
// one AXI write transaction (AW, then W beats, then B).
module dcache_wb_axi
    import dcache_wb_axi_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic         aclk,
    input  logic         areset,

    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy,

    input  logic [31:0]  rd_addr,
    output logic         rd_conflict,

    output logic [3:0]   awid,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic [1:0]   awlock,
    output logic [3:0]   awcache,
    output logic [2:0]   awprot,
    output logic         awvalid,
    input  logic         awready,

    output logic [3:0]   wid,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,

    input  logic [3:0]   bid,
    input  logic [1:0]   bresp,
    input  logic         bvalid,
    output logic         bready
);

    state_e         state_q, state_d;
    logic [1:0]     beat_q, beat_d;
    logic [2:0]     type_q, type_d;
    logic [31:0]    addr_q, addr_d;
    logic [3:0]     strb_q, strb_d;
    logic [127:0]   data_q, data_d;

    logic           is_line;
    logic [31:0]    line_word;

    assign is_line = (type_q == WrLine);

    always_comb begin
        unique case (beat_q)
            2'd0:    line_word = data_q[31:0];
            2'd1:    line_word = data_q[63:32];
            2'd2:    line_word = data_q[95:64];
            default: line_word = data_q[127:96];
        endcase
    end

    // Every handshake-facing output is gated by areset so nothing leaks out during reset.
    always_comb begin
        wr_rdy      = (state_q == StIdle) && !areset;
        awvalid     = (state_q == StAw) && !areset;
        wvalid      = (state_q == StW) && !areset;
        bready      = (state_q == StB) && !areset;
        rd_conflict = (state_q != StIdle) && !areset && (rd_addr[31:4] == addr_q[31:4]);

        awid    = AXI_ID;
        awaddr  = is_line ? {addr_q[31:4], 4'b0000} : addr_q;
        awlen   = is_line ? AxiLenLine : AxiLenSingle;
        awsize  = axi_size(type_q);
        awburst = AxiBurstIncr;
        awlock  = 2'b00;
        awcache = 4'b0000;
        awprot  = 3'b000;

        wid   = AXI_ID;
        wdata = is_line ? line_word : data_q[31:0];
        wstrb = is_line ? 4'hf : strb_q;
        wlast = is_line ? (beat_q == 2'd3) : (beat_q == 2'd0);
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        type_d  = type_q;
        addr_d  = addr_q;
        strb_d  = strb_q;
        data_d  = data_q;

        unique case (state_q)
            StIdle: begin
                if (wr_req) begin
                    type_d  = wr_type;
                    addr_d  = wr_addr;
                    strb_d  = wr_wstrb;
                    data_d  = wr_data;
                    beat_d  = 2'd0;
                    state_d = StAw;
                end
            end
            StAw: begin
                if (awready) state_d = StW;
            end
            StW: begin
                // The counter holds on the last beat rather than wrapping.
                if (wready) begin
                    if (wlast) state_d = StB;
                    else       beat_d  = beat_q + 2'd1;
                end
            end
            default: begin
                if (bvalid) state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= StIdle;
            beat_q  <= 2'd0;
            type_q  <= 3'd0;
            addr_q  <= 32'd0;
            strb_q  <= 4'd0;
            data_q  <= 128'd0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            strb_q  <= strb_d;
            data_q  <= data_d;
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{bid, bresp, rd_addr[3:0]};

endmodule

// File: tb/tb_dcache_wb_axi.sv
// Self-checking bench for dcache_wb_axi: directed scenarios plus randomized writes with
// randomized AXI ready/valid, checked against a transaction-level expectation per write.
module tb_dcache_wb_axi;

    logic         aclk = 1'b0;
    logic         areset;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy;
    logic [31:0]  rd_addr;
    logic         rd_conflict;
    logic [3:0]   awid;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic [1:0]   awlock;
    logic [3:0]   awcache;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [3:0]   wid;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [3:0]   bid;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    dcache_wb_axi #(.AXI_ID(4'd1)) dut (
        .aclk(aclk), .areset(areset),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy),
        .rd_addr(rd_addr), .rd_conflict(rd_conflict),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
        .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_awvalid"}, awvalid, 1'b0);
        chk({tag, "_wvalid"}, wvalid, 1'b0);
        chk({tag, "_bready"}, bready, 1'b0);
        chk({tag, "_wr_rdy"}, wr_rdy, 1'b0);
        chk({tag, "_conflict"}, rd_conflict, 1'b0);
    endtask

    // One write from acceptance to B handshake. Entered and left just after a falling edge.
    // exp_cycles: expected cycles from the one after acceptance up to the B handshake (0 = skip).
    task automatic run_txn(input logic [2:0] ty, input logic [31:0] ad, input logic [3:0] sb,
                           input logic [127:0] dt, input bit rnd, input int aw_hold_in,
                           input bit w_tog, input int abort_beat, input int exp_cycles,
                           input logic [31:0] ra);
        bit          line;
        logic [31:0] e_awaddr;
        logic [7:0]  e_awlen;
        logic [2:0]  e_size;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
        int          nb;
        int          phase;
        int          beat;
        int          n;
        int          wcyc;
        int          aw_hold;
        bit          aborted;

        line     = (ty == 3'b100);
        e_awaddr = line ? (ad & 32'hFFFF_FFF0) : ad;
        e_awlen  = line ? 8'd3 : 8'd0;
        e_size   = (ty == 3'b000) ? 3'd0 : (ty == 3'b001) ? 3'd1 : 3'd2;
        nb       = line ? 4 : 1;
        phase    = 0;
        beat     = 0;
        n        = 0;
        wcyc     = 0;
        aw_hold  = aw_hold_in;
        aborted  = 1'b0;

        wr_req   = 1'b1;
        wr_type  = ty;
        wr_addr  = ad;
        wr_wstrb = sb;
        wr_data  = dt;
        rd_addr  = ra;
        awready  = 1'b0;
        wready   = 1'b0;
        bvalid   = 1'b0;
        #1;
        chk("accept_wr_rdy", wr_rdy, 1'b1);
        chk("accept_conflict", rd_conflict, 1'b0);
        @(negedge aclk);
        // Scramble the request inputs so any late sampling shows up.
        wr_req   = 1'b0;
        wr_type  = 3'($urandom);
        wr_addr  = $urandom;
        wr_wstrb = 4'($urandom);
        wr_data  = {$urandom, $urandom, $urandom, $urandom};

        while (phase < 3 && n < 200 && !aborted) begin
            awready = (aw_hold > 0) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            wready  = w_tog ? (wcyc % 2 == 0) : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            bvalid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bid     = 4'($urandom);
            bresp   = 2'($urandom);
            if (aw_hold > 0) aw_hold--;
            #1;
            chk("busy_wr_rdy", wr_rdy, 1'b0);
            chk("busy_conflict", rd_conflict, ra[31:4] == ad[31:4]);
            chk("aw_w_exclusive", awvalid && wvalid, 1'b0);
            if (phase == 0) begin
                chk("awvalid", awvalid, 1'b1);
                chk("awaddr", awaddr, e_awaddr);
                chk("awlen", awlen, e_awlen);
                chk("awsize", awsize, e_size);
                chk("aw_fixed", {awid, awburst, awlock, awcache, awprot},
                    {4'd1, 2'b01, 2'b00, 4'b0000, 3'b000});
                chk("aw_bready", bready, 1'b0);
                if (awready) phase = 1;
            end else if (phase == 1) begin
                e_wdata = line ? dt[beat*32 +: 32] : dt[31:0];
                e_wstrb = line ? 4'hf : sb;
                chk("wvalid", wvalid, 1'b1);
                chk("wdata", wdata, e_wdata);
                chk("wstrb", wstrb, e_wstrb);
                chk("wlast", wlast, beat == nb - 1);
                chk("wid", wid, 4'd1);
                chk("w_bready", bready, 1'b0);
                wcyc++;
                if (beat == abort_beat) begin
                    areset = 1'b1;
                    #1;
                    chk_quiet("rst_now");
                    @(negedge aclk);
                    #1;
                    chk_quiet("rst_held");
                    areset  = 1'b0;
                    aborted = 1'b1;
                end else if (wready) begin
                    beat++;
                    if (beat == nb) phase = 2;
                end
            end else begin
                chk("bready", bready, 1'b1);
                chk("b_wvalid", wvalid, 1'b0);
                chk("b_awvalid", awvalid, 1'b0);
                if (bvalid) phase = 3;
            end
            n++;
            if (!aborted) @(negedge aclk);
        end

        chk("txn_timeout", n < 200, 1'b1);
        if (!aborted) begin
            chk("w_handshakes", beat, nb);
            if (exp_cycles > 0) chk("occupancy", n, exp_cycles);
        end
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        #1;
        chk("done_wr_rdy", wr_rdy, 1'b1);
        chk("done_conflict", rd_conflict, 1'b0);
    endtask

    initial begin
        logic [2:0]  types [4];
        logic [31:0] ad;
        logic [31:0] ra;
        types = '{3'b000, 3'b001, 3'b010, 3'b100};

        areset   = 1'b1;
        wr_req   = 1'b0;
        wr_type  = 3'b000;
        wr_addr  = 32'd0;
        wr_wstrb = 4'd0;
        wr_data  = 128'd0;
        rd_addr  = 32'd0;
        awready  = 1'b0;
        wready   = 1'b0;
        bid      = 4'd0;
        bresp    = 2'd0;
        bvalid   = 1'b0;
        #1;
        chk_quiet("reset_async_view");
        @(negedge aclk);
        @(negedge aclk);
        #1;
        chk_quiet("reset");
        areset = 1'b0;
        #1;
        chk("post_reset_wr_rdy", wr_rdy, 1'b1);
        @(negedge aclk);

        // Line write, everything ready: AW, 4 W beats, B.
        run_txn(3'b100, 32'h1C00_0124, 4'h0,
                {32'h44, 32'h33, 32'h22, 32'h11}, 1'b0, 0, 1'b0, -1, 6, 32'h0);
        // Byte write with upper strobe.
        run_txn(3'b000, 32'h1FAF_0003, 4'b1000, 128'h0BAD_0000_0000_0000_0000_0000_AB00_0000,
                1'b0, 0, 1'b0, -1, 3, 32'h0);
        // awready low for 5 cycles.
        run_txn(3'b010, 32'h0000_8008, 4'hf, 128'hDEAD_BEEF, 1'b0, 5, 1'b0, -1, 8, 32'h0);
        // wready toggling 1,0,1,0,... through a line.
        run_txn(3'b100, 32'h0000_4440, 4'h0,
                {32'hA4, 32'hA3, 32'hA2, 32'hA1}, 1'b0, 0, 1'b1, -1, 9, 32'h0);
        // Refill conflict on the same line, then on the next line.
        run_txn(3'b100, 32'h0000_1230, 4'h0, {4{32'h5A5A_0001}}, 1'b0, 0, 1'b0, -1, 6,
                32'h0000_123C);
        run_txn(3'b100, 32'h0000_1230, 4'h0, {4{32'h5A5A_0002}}, 1'b0, 0, 1'b0, -1, 6,
                32'h0000_1240);
        // Reset during W beat 2, then a fresh line write.
        run_txn(3'b100, 32'h0000_2000, 4'h0, {32'hC4, 32'hC3, 32'hC2, 32'hC1}, 1'b0, 0, 1'b0,
                2, 0, 32'h0000_2004);
        run_txn(3'b100, 32'h0000_3010, 4'h0, {32'hD4, 32'hD3, 32'hD2, 32'hD1}, 1'b0, 0, 1'b0,
                -1, 6, 32'h0);

        for (int i = 0; i < 40; i++) begin
            ad = $urandom;
            ra = ($urandom_range(0, 1) == 1) ? {ad[31:4], 4'($urandom)} : $urandom;
            run_txn(types[$urandom_range(0, 3)], ad, 4'($urandom),
                    {$urandom, $urandom, $urandom, $urandom}, 1'b1, 0, 1'b0, -1, 0, ra);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_wb_axi.md
DCACHE_WB_AXI -- requirements
Module: dcache_wb_axi

Interface
REQ-001 Parameter AXI_ID, default 4'd1, ID driven on awid and wid.
REQ-002 aclk  in  1  sole clock; all state updates on rising edge.
REQ-003 areset  in  1  reset, synchronous, active-high.
REQ-004 wr_req  in  1  dcache write request.
REQ-005 wr_type  in  3  3'b000 byte, 3'b001 half, 3'b010 word, 3'b100 cache line.
REQ-006 wr_addr  in  32  write address.
REQ-007 wr_wstrb  in  4  byte strobe for non-line writes.
REQ-008 wr_data  in  128  line data; word N in bits [32N+31:32N]; non-line data in [31:0].
REQ-009 wr_rdy  out  1  block can accept a request this cycle.
REQ-010 rd_addr  in  32  address of the pending refill read from the dcache.
REQ-011 rd_conflict  out  1  refill read must stall due to a buffered write to the same line.
REQ-012 awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  4/32/8/3/2/2/4/3/1  AXI write-address channel.
REQ-013 awready  in  1.
REQ-014 wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1  AXI write-data channel.
REQ-015 wready  in  1.
REQ-016 bid  in  4; bresp  in  2; bvalid  in  1; bready  out  1  AXI write-response channel.

Function
REQ-017 States: IDLE, AW, W, B; wr_rdy SHALL be 1 only in IDLE.
REQ-018 On wr_req&wr_rdy, capture type, address, strobe and data; enter AW next cycle; capture is the only acceptance path.
REQ-019 In AW: awvalid=1; awaddr={addr[31:4],4'b0} for line, else addr; awlen=3 for line, else 0.
REQ-020 awsize: 3'b010 for line/word, 3'b001 half, 3'b000 byte; awburst=2'b01; awlock, awcache, awprot=0.
REQ-021 AW->W on awvalid&awready; AW payload stable while awvalid=1 and not ready.
REQ-022 In W: wvalid=1; 2-bit beat counter starts at 0 and increments on wvalid&wready.
REQ-023 Line wdata=word[beat], wstrb=4'hf; non-line wdata=data[31:0], wstrb=captured wr_wstrb.
REQ-024 wlast=1 on beat 3 for line and on beat 0 for non-line; W->B on a handshake with wlast=1.
REQ-025 In B: bready=1; B->IDLE on bvalid; bid and bresp are ignored.
REQ-026 Next request is accepted no earlier than the cycle after the B handshake; minimum line occupancy is 7 cycles.
REQ-027 rd_conflict=(state!=IDLE) && rd_addr[31:4]==captured addr[31:4]; combinational.
REQ-028 awvalid and wvalid are never 1 in the same cycle.
REQ-029 Counter does not wrap past 3 within a burst; it resets to 0 on each acceptance.

Reset
REQ-030 While areset=1, next edge: state=IDLE, beat=0, captured registers 0.
REQ-031 While areset=1: awvalid=0, wvalid=0, bready=0, wr_rdy=0, rd_conflict=0.
REQ-032 wr_rdy=1 in the first cycle after areset deasserts.
REQ-033 Reset mid-burst abandons the transaction with no further AXI beats; the fabric is reset together.

Structure
REQ-034 Shared package/header holds wr_type encodings, state encodings and AXI burst/size constants.
REQ-035 No sub-module; single FSM plus datapath registers.

Verification
REQ-036 Line write, addr 0x1C000124, data words 0x11,0x22,0x33,0x44, ready always 1 -> awaddr 0x1C000120, awlen 3; wdata 0x11..0x44 with wstrb f; wlast on 4th beat; wr_rdy back after bvalid.
REQ-037 Byte write, addr 0x1FAF0003, wstrb 4'b1000 -> awsize 0, awlen 0, single beat, wlast=1, wstrb 4'b1000.
REQ-038 awready held low 5 cycles -> awaddr/awlen stable; wvalid=0 throughout; wr_rdy=0.
REQ-039 wready toggled 1,0,1,0 during line -> wdata advances only on handshake beats; exactly 4 handshakes.
REQ-040 Line buffered at 0x00001230, rd_addr 0x0000123C -> rd_conflict=1; rd_addr 0x00001240 -> 0; after B handshake -> 0.
REQ-041 areset asserted during W beat 2 -> next cycle valids 0; after release, wr_rdy=1 and new write runs from beat 0.
